// File: rtl/lcd_init_seq.sv
//-----------------------------------------------------------------------------
// Module  : lcd_init_seq
// Purpose : ST7789 power-up sequencer and pixel streamer in front of the SPI
//           byte engine. Pulses the panel reset, plays the init table, then
//           sets a full-screen window, issues RAMWR and streams RGB565 frames.
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module lcd_init_seq #(
  parameter int MS_CYCLES = 50_000,
  parameter int T_RST_MS  = 10,
  parameter int T_BOOT_MS = 120,
  parameter int H_RES     = 240,
  parameter int V_RES     = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        lcd_rst_n,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  input  logic        spi_done,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        init_done,
  output logic        frame_sof
);

  localparam int NPIX     = H_RES * V_RES;
  localparam int PCNT_W   = $clog2(NPIX) + 1;
  localparam int RST_CYC  = T_RST_MS * MS_CYCLES;
  localparam int BOOT_CYC = T_BOOT_MS * MS_CYCLES;
  localparam int DLY_MAX  = 255 * MS_CYCLES;
  localparam int CNT_MAX  = (DLY_MAX > BOOT_CYC) ? ((DLY_MAX > RST_CYC) ? DLY_MAX : RST_CYC)
                                                 : ((BOOT_CYC > RST_CYC) ? BOOT_CYC : RST_CYC);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [7:0] H_END = 8'(H_RES - 1);
  localparam logic [7:0] V_END = 8'(V_RES - 1);

  typedef enum logic [2:0] {
    ST_HW_RST, ST_BOOT_WAIT, ST_FETCH, ST_SEND, ST_WAIT, ST_DELAY, ST_WIN, ST_PIX
  } state_t;

  // What the byte currently in flight belongs to; decides where WAIT goes.
  typedef enum logic [1:0] {SRC_INIT, SRC_WIN, SRC_PIX_HI, SRC_PIX_LO} src_t;

  // Init table entry {type, val}: 00 cmd, 01 data, 10 delay ms, 11 end.
  function automatic logic [9:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {2'b00, 8'h11};
      4'd1:    init_entry = {2'b10, 8'd120};
      4'd2:    init_entry = {2'b00, 8'h3A};
      4'd3:    init_entry = {2'b01, 8'h55};
      4'd4:    init_entry = {2'b00, 8'h36};
      4'd5:    init_entry = {2'b01, 8'h00};
      4'd6:    init_entry = {2'b00, 8'h21};
      4'd7:    init_entry = {2'b00, 8'h13};
      4'd8:    init_entry = {2'b00, 8'h29};
      4'd9:    init_entry = {2'b10, 8'd10};
      default: init_entry = {2'b11, 8'h00};
    endcase
  endfunction

  // Window / RAMWR sequence entry {dc, byte}.
  function automatic logic [8:0] win_entry(input logic [3:0] widx);
    case (widx)
      4'd0:    win_entry = {1'b0, 8'h2A};
      4'd4:    win_entry = {1'b1, H_END};
      4'd5:    win_entry = {1'b0, 8'h2B};
      4'd9:    win_entry = {1'b1, V_END};
      4'd10:   win_entry = {1'b0, 8'h2C};
      default: win_entry = {1'b1, 8'h00};
    endcase
  endfunction

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        widx_q, widx_d;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]        pix_lo_q, pix_lo_d;
  logic              lcd_rst_n_q, lcd_rst_n_d;
  logic              spi_start_q, spi_start_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic              spi_dc_q, spi_dc_d;
  logic              pix_ready_q, pix_ready_d;
  logic              init_done_q, init_done_d;
  logic              frame_sof_q, frame_sof_d;

  logic              do_init, do_win;
  logic [3:0]        tgt_idx, tgt_widx;
  logic [9:0]        tbl;
  logic [8:0]        wbyte;

  // Next-state logic; table/window dispatch is shared so a byte can follow spi_done directly.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    widx_d      = widx_q;
    pix_cnt_d   = pix_cnt_q;
    pix_lo_d    = pix_lo_q;
    spi_data_d  = spi_data_q;
    spi_dc_d    = spi_dc_q;
    init_done_d = init_done_q;
    frame_sof_d = 1'b0;
    do_init     = 1'b0;
    do_win      = 1'b0;
    tgt_idx     = idx_q;
    tgt_widx    = widx_q;
    tbl         = init_entry(tgt_idx);
    wbyte       = win_entry(tgt_widx);

    case (state_q)
      ST_HW_RST: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = ST_BOOT_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BOOT_WAIT: begin
        if (cnt_q == CNT_W'(BOOT_CYC - 1)) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FETCH: do_init = 1'b1;
      ST_SEND:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_done) begin
          case (src_q)
            SRC_INIT: begin
              do_init = 1'b1;
              tgt_idx = idx_q + 4'd1;
            end
            SRC_WIN: begin
              if (widx_q == 4'd10) begin
                state_d   = ST_PIX;
                pix_cnt_d = '0;
              end else begin
                do_win   = 1'b1;
                tgt_widx = widx_q + 4'd1;
              end
            end
            SRC_PIX_HI: begin
              state_d    = ST_SEND;
              spi_data_d = pix_lo_q;
              spi_dc_d   = 1'b1;
              src_d      = SRC_PIX_LO;
            end
            default: begin
              if (pix_cnt_q == PCNT_W'(NPIX)) begin
                do_win    = 1'b1;
                tgt_widx  = 4'd0;
                pix_cnt_d = '0;
              end else begin
                state_d = ST_PIX;
              end
            end
          endcase
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          do_init = 1'b1;
          tgt_idx = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WIN: do_win = 1'b1;
      ST_PIX: begin
        if (pix_valid && pix_ready_q) begin
          pix_lo_d    = pix_data[7:0];
          pix_cnt_d   = pix_cnt_q + 1'b1;
          frame_sof_d = (pix_cnt_q == '0);
          state_d     = ST_SEND;
          spi_data_d  = pix_data[15:8];
          spi_dc_d    = 1'b1;
          src_d       = SRC_PIX_HI;
        end
      end
      default: state_d = ST_HW_RST;
    endcase

    tbl   = init_entry(tgt_idx);
    wbyte = win_entry(tgt_widx);

    if (do_init) begin
      idx_d = tgt_idx;
      src_d = SRC_INIT;
      case (tbl[9:8])
        2'b00, 2'b01: begin
          state_d    = ST_SEND;
          spi_data_d = tbl[7:0];
          spi_dc_d   = tbl[8];
        end
        2'b10: begin
          state_d = ST_DELAY;
          cnt_d   = (tbl[7:0] == 8'd0) ? '0 : CNT_W'(int'(tbl[7:0]) * MS_CYCLES - 1);
        end
        default: begin
          state_d     = ST_WIN;
          init_done_d = 1'b1;
          widx_d      = 4'd0;
        end
      endcase
    end

    if (do_win) begin
      widx_d     = tgt_widx;
      src_d      = SRC_WIN;
      state_d    = ST_SEND;
      spi_dc_d   = wbyte[8];
      spi_data_d = wbyte[7:0];
    end

    spi_start_d = (state_d == ST_SEND);
    pix_ready_d = (state_d == ST_PIX);
    lcd_rst_n_d = (state_d != ST_HW_RST);
  end

  // State and registered outputs; async reset returns everything to HW_RST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HW_RST;
      src_q       <= SRC_INIT;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      widx_q      <= 4'd0;
      pix_cnt_q   <= '0;
      pix_lo_q    <= 8'd0;
      lcd_rst_n_q <= 1'b0;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'd0;
      spi_dc_q    <= 1'b0;
      pix_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      frame_sof_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      widx_q      <= widx_d;
      pix_cnt_q   <= pix_cnt_d;
      pix_lo_q    <= pix_lo_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      spi_dc_q    <= spi_dc_d;
      pix_ready_q <= pix_ready_d;
      init_done_q <= init_done_d;
      frame_sof_q <= frame_sof_d;
    end
  end

  assign lcd_rst_n = lcd_rst_n_q;
  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;
  assign spi_dc    = spi_dc_q;
  assign pix_ready = pix_ready_q;
  assign init_done = init_done_q;
  assign frame_sof = frame_sof_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_init_seq.sv
//-----------------------------------------------------------------------------
// Module  : tb_lcd_init_seq
// Purpose : Self-checking bench for lcd_init_seq with an SPI done model,
//           a randomized pixel source and an expected byte-stream model.
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_init_seq;

  localparam int MS   = 10;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic        clk, rst_n;
  logic        lcd_rst_n, spi_start, spi_dc, spi_done;
  logic [7:0]  spi_data;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, init_done, frame_sof;

  lcd_init_seq #(.MS_CYCLES(MS), .T_RST_MS(10), .T_BOOT_MS(120), .H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rst_n(lcd_rst_n), .spi_start(spi_start),
    .spi_data(spi_data), .spi_dc(spi_dc), .spi_done(spi_done), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .init_done(init_done), .frame_sof(frame_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte: gap kind 0 any, 1 exactly one cycle after done, 2 >=1200, 3 >=100.
  typedef struct packed {logic [7:0] b; logic dc; logic [1:0] kind;} exp_t;
  exp_t        exp_q[$];
  logic [15:0] pix_mem[0:63];
  int          pix_limit = 0;

  function automatic exp_t mk(input logic [7:0] b, input logic dc, input logic [1:0] k);
    mk.b = b; mk.dc = dc; mk.kind = k;
  endfunction

  // Reference stream: init table, then per frame window+RAMWR and two bytes per pixel.
  task automatic build_exp(input int nfull, input int extra);
    int k = 0;
    exp_q.delete();
    exp_q.push_back(mk(8'h11, 0, 0)); exp_q.push_back(mk(8'h3A, 0, 2));
    exp_q.push_back(mk(8'h55, 1, 1)); exp_q.push_back(mk(8'h36, 0, 1));
    exp_q.push_back(mk(8'h00, 1, 1)); exp_q.push_back(mk(8'h21, 0, 1));
    exp_q.push_back(mk(8'h13, 0, 1)); exp_q.push_back(mk(8'h29, 0, 1));
    for (int f = 0; f <= nfull; f++) begin
      exp_q.push_back(mk(8'h2A, 0, (f == 0) ? 2'd3 : 2'd1));
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(8'h00, 1, 1));
      exp_q.push_back(mk(8'(H - 1), 1, 1));
      exp_q.push_back(mk(8'h2B, 0, 1));
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(8'h00, 1, 1));
      exp_q.push_back(mk(8'(V - 1), 1, 1));
      exp_q.push_back(mk(8'h2C, 0, 1));
      for (int p = 0; p < ((f < nfull) ? NPIX : extra); p++) begin
        exp_q.push_back(mk(pix_mem[k][15:8], 1, 0));
        exp_q.push_back(mk(pix_mem[k][7:0], 1, 1));
        k++;
      end
    end
    pix_limit = k;
  endtask

  // SPI engine model: done pulse 16 cycles after an accepted start.
  int sc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= 0; spi_done <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (sc != 0) begin
        sc <= sc - 1;
        if (sc == 1) spi_done <= 1'b1;
      end else if (spi_start) begin
        sc <= 16;
      end
    end
  end

  // Byte monitor: order, dc, hold-until-done, one start per done, gaps, init_done.
  int       cyc = 0, last_done = 0, pops = 0;
  logic     busy = 1'b0;
  logic [8:0] lat;
  exp_t     e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (spi_done) begin
        check("hold_dc_data", {23'd0, spi_dc, spi_data}, {23'd0, lat});
        busy = 1'b0;
        last_done = cyc;
      end
      if (spi_start) begin
        check("one_start_per_done", {31'd0, busy}, 32'd0);
        check("unexpected_byte", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte_dc_data", {23'd0, spi_dc, spi_data}, {23'd0, e.dc, e.b});
          check("init_done_at_byte", {31'd0, init_done}, 32'(pops >= 8));
          if (e.kind == 2'd1) check("tight_gap", 32'(cyc - last_done), 32'd1);
          if (e.kind == 2'd2) check("gap_ge_1200", 32'(cyc - last_done >= 1200), 32'd1);
          if (e.kind == 2'd3) check("gap_ge_100", 32'(cyc - last_done >= 100), 32'd1);
        end
        pops++;
        busy = 1'b1;
        lat = {spi_dc, spi_data};
      end
    end
  end

  // Pixel source with random valid, frame_sof model and a one-off backpressure window.
  int   pix_idx = 0, sof_cnt = 0, starts, rdy_low;
  logic acc = 1'b0, sof_exp = 1'b0, bp_done = 1'b0;
  initial begin
    pix_valid = 1'b0;
    pix_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pix_idx = 0; acc = 1'b0; sof_exp = 1'b0; sof_cnt = 0; pix_valid = 1'b0;
      end else begin
        check("frame_sof", {31'd0, frame_sof}, {31'd0, sof_exp});
        if (frame_sof) sof_cnt++;
        sof_exp = 1'b0;
        if (acc) begin
          pix_idx++;
          acc = 1'b0;
        end
        pix_data = pix_mem[pix_idx];
        if (!bp_done && pix_idx == 5 && pix_ready) begin
          pix_valid = 1'b0; starts = 0; rdy_low = 0;
          repeat (50) begin
            @(negedge clk);
            if (spi_start) starts++;
            if (!pix_ready) rdy_low++;
          end
          check("bp_no_start", 32'(starts), 32'd0);
          check("bp_ready_held", 32'(rdy_low), 32'd0);
          bp_done = 1'b1;
        end
        pix_valid = (pix_idx < pix_limit) && ($urandom_range(0, 3) != 0);
        if (pix_valid && pix_ready) begin
          acc = 1'b1;
          sof_exp = ((pix_idx % NPIX) == 0);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_lcd_rst_n"}, {31'd0, lcd_rst_n}, 32'd0);
    check({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
    check({tag, "_spi_data"},  {24'd0, spi_data}, 32'd0);
    check({tag, "_spi_dc"},    {31'd0, spi_dc}, 32'd0);
    check({tag, "_pix_ready"}, {31'd0, pix_ready}, 32'd0);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    check({tag, "_frame_sof"}, {31'd0, frame_sof}, 32'd0);
  endtask

  task automatic reset_and_t1();
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    pops = 0;
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!lcd_rst_n && n < 500);
    check("t_rst_cycles", 32'(n), 32'd100);
    n = 0;
    do begin @(negedge clk); n++; end while (!spi_start && n < 3000);
    check("t_boot_in_1200_1205", 32'(n >= 1200 && n <= 1205), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    pix_mem[0] = 16'hF800;
    for (int i = 1; i < 64; i++) pix_mem[i] = 16'($urandom);

    // Two full frames, then window and first pixels of a third.
    build_exp(2, 2);
    reset_and_t1();
    wait_drain();
    check("sof_count_run1", 32'(sof_cnt), 32'd3);
    check("bp_window_seen", {31'd0, bp_done}, 32'd1);

    // Asynchronous reset while 3Ah is in flight.
    build_exp(0, 3);
    reset_and_t1();
    n = 0;
    while (pops < 2 && n < 5000) begin @(negedge clk); n++; end
    check("reached_3A", 32'(pops), 32'd2);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midbyte");
    repeat (20) @(negedge clk);
    check("no_done_after_reset", {31'd0, spi_done}, 32'd0);

    build_exp(0, 3);
    reset_and_t1();
    wait_drain();
    check("sof_count_rerun", 32'(sof_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
